// File: rtl/cpu_seq_pkg.sv
// Shared types and default stage latencies for the CPU stage sequencer.
package cpu_seq_pkg;

  typedef enum logic [1:0] {
    MODE_STALL = 2'd0,
    MODE_LOAD  = 2'd1,
    MODE_EXEC  = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_EXECUTE  = 3'd2,
    ST_MEMORY   = 3'd3,
    ST_WRITEREG = 3'd4,
    ST_STOP     = 3'd5
  } stage_t;

  localparam int unsigned DEF_LAT_W      = 4;
  localparam int unsigned DEF_LAT_FETCH  = 0;
  localparam int unsigned DEF_LAT_DECODE = 0;
  localparam int unsigned DEF_LAT_EXEC   = 5;
  localparam int unsigned DEF_LAT_MEM    = 1;
  localparam int unsigned DEF_LAT_WB     = 1;

endpackage

// File: rtl/seq_stage_timer.sv
// Per-stage latency counter: clears on stage change, holds while asked, flags target reached.
module seq_stage_timer #(
  parameter int unsigned LAT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             hold,
  input  logic [LAT_W-1:0] target,
  output logic             done
);

  logic [LAT_W-1:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      count <= '0;
    else if (clear) count <= '0;
    else if (!hold) count <= count + LAT_W'(1);
  end

  assign done = (count == target);

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Boot-mode machine, per-stage walk with latency/stall handling, PC and retire/cycle counters.
module cpu_stage_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned LAT_W      = DEF_LAT_W,
  parameter int unsigned LAT_FETCH  = DEF_LAT_FETCH,
  parameter int unsigned LAT_DECODE = DEF_LAT_DECODE,
  parameter int unsigned LAT_EXEC   = DEF_LAT_EXEC,
  parameter int unsigned LAT_MEM    = DEF_LAT_MEM,
  parameter int unsigned LAT_WB     = DEF_LAT_WB,
  parameter logic [7:0]  BOOT_BYTE  = 8'hAA
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 load_done,
  input  logic                 exec_valid,
  input  logic                 halt_req,
  input  logic [PC_WIDTH-1:0]  npc,
  input  logic                 step_mode,
  input  logic                 step_req,
  output logic [1:0]           mode,
  output logic [2:0]           stage,
  output logic [4:0]           stage_en,
  output logic                 wb_commit,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [CNT_WIDTH-1:0] retire_count,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [7:0]           led
);

  mode_t                mode_q, mode_d;
  stage_t               stage_q, stage_d;
  logic                 step_wait_q, step_wait_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0] retire_q, retire_d;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [LAT_W-1:0]     target;
  logic                 done;
  logic                 boot;

  assign boot = rx_ready && (rx_data == BOOT_BYTE);

  always_comb begin
    target = '0;
    case (stage_q)
      ST_FETCH:    target = LAT_W'(LAT_FETCH);
      ST_DECODE:   target = LAT_W'(LAT_DECODE);
      ST_EXECUTE:  target = LAT_W'(LAT_EXEC);
      ST_MEMORY:   target = LAT_W'(LAT_MEM);
      ST_WRITEREG: target = LAT_W'(LAT_WB);
      default:     target = '0;
    endcase
  end

  // Counter restarts on any stage/mode entry and otherwise saturates at its target.
  seq_stage_timer #(.LAT_W(LAT_W)) u_timer (
    .clk    (clk),
    .rstn   (rstn),
    .clear  ((stage_d != stage_q) || (mode_q != MODE_EXEC)),
    .hold   (done),
    .target (target),
    .done   (done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q      <= MODE_STALL;
      stage_q     <= ST_FETCH;
      step_wait_q <= 1'b0;
      pc_q        <= '0;
      retire_q    <= '0;
      cycle_q     <= '0;
    end else begin
      mode_q      <= mode_d;
      stage_q     <= stage_d;
      step_wait_q <= step_wait_d;
      pc_q        <= pc_d;
      retire_q    <= retire_d;
      cycle_q     <= cycle_d;
    end
  end

  always_comb begin
    mode_d      = mode_q;
    stage_d     = stage_q;
    step_wait_d = step_wait_q;
    pc_d        = pc_q;
    retire_d    = retire_q;
    cycle_d     = cycle_q;
    case (mode_q)
      MODE_STALL: if (boot) mode_d = MODE_LOAD;
      MODE_LOAD: begin
        if (load_done) begin
          mode_d  = MODE_EXEC;
          stage_d = ST_FETCH;
        end
      end
      MODE_EXEC: begin
        if (stage_q == ST_STOP) begin
          if (boot) begin
            mode_d  = MODE_LOAD;
            stage_d = ST_FETCH;
            pc_d    = '0;
          end
        end else begin
          cycle_d = cycle_q + CNT_WIDTH'(1);
          if (step_wait_q) begin
            if (step_req) begin
              step_wait_d = 1'b0;
              stage_d     = ST_FETCH;
            end
          end else if (stage_en != 5'd0) begin
            case (stage_q)
              ST_FETCH:   stage_d = ST_DECODE;
              ST_DECODE:  stage_d = ST_EXECUTE;
              ST_EXECUTE: stage_d = ST_MEMORY;
              ST_MEMORY: begin
                pc_d    = npc;
                stage_d = ST_WRITEREG;
              end
              ST_WRITEREG: begin
                retire_d = retire_q + CNT_WIDTH'(1);
                if (halt_req)       stage_d = ST_STOP;
                else if (step_mode) step_wait_d = 1'b1;
                else                stage_d = ST_FETCH;
              end
              default: stage_d = ST_FETCH;
            endcase
          end
        end
      end
      default: mode_d = MODE_STALL;
    endcase
  end

  always_comb begin
    stage_en  = 5'd0;
    wb_commit = 1'b0;
    if ((mode_q == MODE_EXEC) && (stage_q != ST_STOP) && !step_wait_q && done &&
        ((stage_q != ST_EXECUTE) || exec_valid))
      stage_en = 5'd1 << stage_q;
    wb_commit = stage_en[4];
  end

  assign mode         = mode_q;
  assign stage        = stage_q;
  assign pc           = pc_q;
  assign retire_count = retire_q;
  assign cycle_count  = cycle_q;
  assign led          = {mode_q, stage_q, pc_q[4:2]};

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Randomised and directed checks of cpu_stage_sequencer against a per-cycle behavioural model.
module tb_cpu_stage_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        load_done = 1'b0;
  logic        exec_valid = 1'b0;
  logic        halt_req = 1'b0;
  logic [31:0] npc = 32'd0;
  logic        step_mode = 1'b0;
  logic        step_req = 1'b0;
  logic [1:0]  mode;
  logic [2:0]  stage;
  logic [4:0]  stage_en;
  logic        wb_commit;
  logic [31:0] pc;
  logic [31:0] retire_count;
  logic [31:0] cycle_count;
  logic [7:0]  led;

  cpu_stage_sequencer dut (
    .clk(clk), .rstn(rstn), .rx_ready(rx_ready), .rx_data(rx_data),
    .load_done(load_done), .exec_valid(exec_valid), .halt_req(halt_req),
    .npc(npc), .step_mode(step_mode), .step_req(step_req),
    .mode(mode), .stage(stage), .stage_en(stage_en), .wb_commit(wb_commit),
    .pc(pc), .retire_count(retire_count), .cycle_count(cycle_count), .led(led)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: stage index, cycles already spent in it, and architectural counters.
  int          lat [5] = '{0, 0, 5, 1, 1};
  int          m_mode, m_stage, m_elapsed;
  bit          m_wait;
  logic [31:0] m_pc, m_ret, m_cyc;
  logic [4:0]  seen_en;
  logic        seen_wb;

  task automatic model_reset();
    m_mode = 0; m_stage = 0; m_elapsed = 0; m_wait = 0;
    m_pc = 0; m_ret = 0; m_cyc = 0;
  endtask

  function automatic logic [4:0] model_en();
    logic [4:0] e;
    e = 5'd0;
    if (m_mode == 2 && m_stage < 5 && !m_wait && m_elapsed >= lat[m_stage] &&
        (m_stage != 2 || exec_valid))
      e[m_stage] = 1'b1;
    return e;
  endfunction

  task automatic model_advance(input logic [4:0] e);
    bit boot;
    boot = rx_ready && (rx_data == 8'hAA);
    if (m_mode == 0) begin
      if (boot) m_mode = 1;
    end else if (m_mode == 1) begin
      if (load_done) begin m_mode = 2; m_stage = 0; m_elapsed = 0; end
    end else if (m_stage == 5) begin
      if (boot) begin m_mode = 1; m_stage = 0; m_pc = 0; m_elapsed = 0; end
    end else begin
      m_cyc = m_cyc + 1;
      if (m_wait) begin
        if (step_req) begin m_wait = 0; m_stage = 0; m_elapsed = 0; end
      end else if (e != 5'd0) begin
        m_elapsed = 0;
        if (m_stage == 3) m_pc = npc;
        if (m_stage == 4) begin
          m_ret = m_ret + 1;
          if (halt_req)       m_stage = 5;
          else if (step_mode) m_wait = 1;
          else                m_stage = 0;
        end else m_stage = m_stage + 1;
      end else m_elapsed = m_elapsed + 1;
    end
  endtask

  // One clock: compare everything at the falling edge, then advance the model on the rising edge.
  task automatic tick();
    logic [4:0] e;
    @(negedge clk);
    e = model_en();
    check("mode", 64'(mode), 64'(m_mode));
    check("stage", 64'(stage), 64'(m_stage));
    check("pc", 64'(pc), 64'(m_pc));
    check("retire", 64'(retire_count), 64'(m_ret));
    check("cycles", 64'(cycle_count), 64'(m_cyc));
    check("stage_en", 64'(stage_en), 64'(e));
    check("wb_commit", 64'(wb_commit), 64'(e[4]));
    check("led", 64'(led), 64'({m_mode[1:0], m_stage[2:0], m_pc[4:2]}));
    seen_en = stage_en;
    seen_wb = wb_commit;
    @(posedge clk);
    model_advance(e);
    #1;
  endtask

  task automatic random_phase(input int n, input bit use_step);
    for (int i = 0; i < n; i++) begin
      exec_valid = 1'($urandom_range(0, 1));
      npc        = $urandom & 32'hFFFF_FFFC;
      rx_ready   = ($urandom_range(0, 7) == 0);
      rx_data    = ($urandom_range(0, 1) == 1) ? 8'hAA : 8'h55;
      if (use_step) begin
        step_mode = ($urandom_range(0, 3) != 0);
        step_req  = ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    rx_ready = 0; step_req = 0; step_mode = 0;
  endtask

  int last_fetch;
  int wb_seen;
  logic [4:0] en_or;
  bit aligned;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("rst_mode", 64'(mode), 64'd0);
    check("rst_stage", 64'(stage), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_en", 64'(stage_en), 64'd0);
    rstn = 1'b1;
    repeat (2) tick();

    // Boot: non-boot byte ignored, boot byte enters LOAD, load_done enters EXEC.
    rx_ready = 1; rx_data = 8'h55; tick(); rx_ready = 0; tick();
    check("mode_after_55", 64'(mode), 64'd0);
    rx_ready = 1; rx_data = 8'hAA; tick(); rx_ready = 0;
    check("mode_after_aa", 64'(mode), 64'd1);
    repeat (3) tick();
    load_done = 1; tick(); load_done = 0;
    check("exec_mode", 64'(mode), 64'd2);
    check("exec_stage", 64'(stage), 64'd0);

    // Three back-to-back instructions at default latency.
    exec_valid = 1; last_fetch = -1;
    for (int k = 0; k < 36; k++) begin
      npc = m_pc + 32'd4;
      tick();
      if (seen_en[0]) begin
        if (last_fetch >= 0) check("period12", 64'(k - last_fetch), 64'd12);
        last_fetch = k;
      end
    end
    check("pc_after3", 64'(pc), 64'd12);
    check("retire3", 64'(retire_count), 64'd3);
    check("cycles36", 64'(cycle_count), 64'd36);

    random_phase(400, 1'b0);

    // Align on an instruction boundary.
    exec_valid = 1; aligned = 0;
    for (int k = 0; k < 40 && !aligned; k++) begin
      if (m_stage == 0 && m_elapsed == 0 && !m_wait) aligned = 1;
      else begin npc = m_pc + 32'd4; tick(); end
    end
    check("align_timeout", 64'(aligned), 64'd1);

    // EXECUTE stalled for 10 cycles once its counter has reached LAT_EXEC.
    wb_seen = 0;
    for (int k = 0; k < 22; k++) begin
      exec_valid = (k >= 17);
      npc = m_pc + 32'd4;
      tick();
      if (k == 16) check("exec_hold_stage", 64'(stage), 64'd2);
      if (k == 17) check("exec_fire", 64'(seen_en), 64'b00100);
      if (seen_wb) wb_seen++;
      if (k == 21) check("period22_wb", 64'(seen_wb), 64'd1);
    end
    check("period22_once", 64'(wb_seen), 64'd1);
    check("period22_stage", 64'(stage), 64'd0);

    // Halt on the second instruction, then restart from STOP.
    exec_valid = 1;
    for (int k = 0; k < 12; k++) begin npc = m_pc + 32'd4; tick(); end
    halt_req = 1;
    for (int k = 0; k < 12; k++) begin npc = m_pc + 32'd4; tick(); end
    halt_req = 0;
    check("halt_stage", 64'(stage), 64'd5);
    en_or = 0;
    for (int k = 0; k < 20; k++) begin npc = $urandom; tick(); en_or |= seen_en; end
    check("halt_no_en", 64'(en_or), 64'd0);
    rx_ready = 1; rx_data = 8'hAA; tick(); rx_ready = 0;
    check("restart_mode", 64'(mode), 64'd1);
    check("restart_pc", 64'(pc), 64'd0);
    load_done = 1; tick(); load_done = 0;

    // Single step: sits in WRITEREG after the commit until step_req.
    step_mode = 1;
    for (int k = 0; k < 12; k++) begin npc = m_pc + 32'd4; tick(); end
    check("step_commit", 64'(seen_wb), 64'd1);
    wb_seen = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (seen_wb) wb_seen++; end
    check("step_no_repeat", 64'(wb_seen), 64'd0);
    check("step_hold_stage", 64'(stage), 64'd4);
    step_req = 1; tick(); step_req = 0;
    check("step_release", 64'(stage), 64'd0);
    step_mode = 0;

    random_phase(400, 1'b1);

    // Asynchronous reset in the middle of MEMORY.
    exec_valid = 1; step_req = 1; aligned = 0;
    for (int k = 0; k < 60 && !aligned; k++) begin
      if (m_stage == 3) aligned = 1;
      else begin npc = m_pc + 32'd4; tick(); end
    end
    step_req = 0;
    check("mem_reach", 64'(aligned), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("arst_pc", 64'(pc), 64'd0);
    check("arst_mode", 64'(mode), 64'd0);
    check("arst_stage", 64'(stage), 64'd0);
    check("arst_en", 64'(stage_en), 64'd0);
    model_reset();
    #3 rstn = 1'b1;
    wb_seen = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (seen_wb) wb_seen++; end
    check("arst_no_commit", 64'(wb_seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
